// File: rtl/bf_console_if.sv
// Core-side character I/O bundle between the bf core and its serial console.
interface bf_console_if;
    logic       print;
    logic [7:0] out;
    logic       kback;
    logic [7:0] keyb;
    logic       tx_full;

    modport master (output print, output out, output kback, input keyb, input tx_full);
    modport slave  (input print, input out, input kback, output keyb, output tx_full);
endinterface

// File: rtl/bf_console.sv
// UART 8N1 console for the bf core: print bytes go out through a TX FIFO,
// received bytes queue in an RX FIFO and are offered on keyb (0x00 = no key).
module bf_console #(
    parameter int CLK_HZ    = 25000000,
    parameter int BAUD      = 115200,
    parameter int FIFO_LOG2 = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    bf_console_if.slave  core,
    output logic         txd,
    input  logic         rxd,
    output logic         tx_ovf,
    output logic         rx_ovf,
    output logic         rx_ferr
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_LOG2:0] tx_wptr, tx_rptr;
    logic               tx_empty, tx_full, tx_push, tx_pop;
    uart_state_t        tx_state, tx_state_d;
    logic [CW-1:0]      tx_cnt, tx_cnt_d;
    logic [2:0]         tx_bit, tx_bit_d;
    logic [7:0]         tx_sh, tx_sh_d;
    logic               txd_d;

    assign tx_empty     = (tx_wptr == tx_rptr);
    assign tx_full      = (tx_wptr[FIFO_LOG2] != tx_rptr[FIFO_LOG2]) &&
                          (tx_wptr[FIFO_LOG2-1:0] == tx_rptr[FIFO_LOG2-1:0]);
    // A pop on the same edge frees a slot, so a full FIFO still takes the byte.
    assign tx_push      = core.print && (!tx_full || tx_pop);
    assign core.tx_full = tx_full;

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_sh_d    = tx_sh;
        tx_pop     = 1'b0;
        txd_d      = 1'b1;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_mem[tx_rptr[FIFO_LOG2-1:0]];
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (tx_cnt == '0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            DATA: begin
                txd_d = tx_sh[0];
                if (tx_cnt == '0) begin
                    tx_cnt_d = DIV_M1;
                    tx_sh_d  = {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7) tx_state_d = STOP;
                    else                tx_bit_d   = tx_bit + 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == '0) tx_state_d = IDLE;
                else              tx_cnt_d   = tx_cnt - 1'b1;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // txd is registered from the current state so the line never glitches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            txd      <= 1'b1;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_sh    <= tx_sh_d;
            txd      <= txd_d;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (core.print && tx_full && !tx_pop) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_LOG2-1:0]] <= core.out;
    end

    logic [1:0]         rx_sync;
    logic               rs;
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_LOG2:0] rx_wptr, rx_rptr, rx_wptr_d, rx_rptr_d;
    logic               rx_empty, rx_full, rx_push, rx_pop, rx_accept, rx_ferr_set, rx_take;
    uart_state_t        rx_state, rx_state_d;
    logic [CW-1:0]      rx_cnt, rx_cnt_d;
    logic [2:0]         rx_bit, rx_bit_d;
    logic [7:0]         rx_sh, rx_sh_d;
    logic               rx_armed, rx_armed_d;
    logic [7:0]         keyb_q, keyb_d;

    assign rs        = rx_sync[1];
    assign rx_empty  = (rx_wptr == rx_rptr);
    assign rx_full   = (rx_wptr[FIFO_LOG2] != rx_rptr[FIFO_LOG2]) &&
                       (rx_wptr[FIFO_LOG2-1:0] == rx_rptr[FIFO_LOG2-1:0]);
    assign rx_pop    = core.kback && !rx_empty;
    assign rx_take   = rx_accept && (rx_sh != 8'h00);
    assign rx_push   = rx_take && (!rx_full || rx_pop);
    assign rx_wptr_d = rx_push ? rx_wptr + 1'b1 : rx_wptr;
    assign rx_rptr_d = rx_pop  ? rx_rptr + 1'b1 : rx_rptr;
    assign core.keyb = keyb_q;

    // rx_armed blocks start detection until the line has been seen idle high.
    always_comb begin
        rx_state_d  = rx_state;
        rx_cnt_d    = rx_cnt;
        rx_bit_d    = rx_bit;
        rx_sh_d     = rx_sh;
        rx_armed_d  = rx_armed;
        rx_accept   = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rs) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_cnt == '0) begin
                    if (!rs) begin
                        rx_cnt_d   = DIV_M1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = DATA;
                    end else begin
                        rx_state_d = IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_d = DIV_M1;
                    rx_sh_d  = {rs, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_state_d = STOP;
                    else                rx_bit_d   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == '0) begin
                    rx_accept   = rs;
                    rx_ferr_set = !rs;
                    rx_armed_d  = rs;
                    rx_state_d  = IDLE;
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // keyb tracks the head as it will be after this edge's push and pop.
    always_comb begin
        keyb_d = 8'h00;
        if (rx_wptr_d != rx_rptr_d) begin
            if (rx_push && (rx_rptr_d == rx_wptr)) keyb_d = rx_sh;
            else                                   keyb_d = rx_mem[rx_rptr_d[FIFO_LOG2-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_sync  <= 2'b11;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_armed <= 1'b0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            keyb_q   <= 8'h00;
            rx_ovf   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_sh    <= rx_sh_d;
            rx_armed <= rx_armed_d;
            rx_wptr  <= rx_wptr_d;
            rx_rptr  <= rx_rptr_d;
            keyb_q   <= keyb_d;
            if (rx_take && rx_full && !rx_pop) rx_ovf  <= 1'b1;
            if (rx_ferr_set)                   rx_ferr <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wptr[FIFO_LOG2-1:0]] <= rx_sh;
    end
endmodule
